// File: rtl/i2c_pkg.sv
// Shared I2C target definitions: FSM state encoding, ACK/NACK bus levels,
// and the 3-sample majority vote used by the optional input filter.
package i2c_pkg;

   typedef enum logic [3:0] {
      IDLE,
      ADDR,
      ADDR_ACK,
      PTR,
      PTR_ACK,
      WDATA,
      WDATA_ACK,
      RDATA,
      RDATA_ACK,
      WAIT_STOP
   } i2c_state_e;

   localparam logic ACK  = 1'b0;
   localparam logic NACK = 1'b1;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/i2c_bus_cond_mod.sv
// SCL/SDA input conditioning: 2-flop synchronizers, optional majority filter
// (I2C_TARGET_GLITCH_FILT_EN), and SCL edge / START / STOP detection.
module i2c_bus_cond_mod
   import i2c_pkg::*;
(
   input  logic b_clk,
   input  logic rst_i,
   input  logic scl_i,
   input  logic sda_i,
   output logic sda_lvl,
   output logic scl_rise,
   output logic scl_fall,
   output logic start_det,
   output logic stop_det
);

   logic [1:0] scl_sync;
   logic [1:0] sda_sync;
   logic       scl_c;
   logic       sda_c;
   logic       scl_q;
   logic       sda_q;

   // Synchronizers reset to 1 so a reset looks like an idle bus.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge b_clk or posedge rst_i) begin
      if (rst_i) begin
         scl_sync <= 2'b11;
         sda_sync <= 2'b11;
      end else begin
         scl_sync <= {scl_sync[0], scl_i};
         sda_sync <= {sda_sync[0], sda_i};
      end
   end

`ifdef I2C_TARGET_GLITCH_FILT_EN
   logic [1:0] scl_hist;
   logic [1:0] sda_hist;
   logic       scl_filt;
   logic       sda_filt;

   always_ff @(posedge b_clk or posedge rst_i) begin
      if (rst_i) begin
         scl_hist <= 2'b11;
         sda_hist <= 2'b11;
         scl_filt <= 1'b1;
         sda_filt <= 1'b1;
      end else begin
         scl_hist <= {scl_hist[0], scl_sync[1]};
         sda_hist <= {sda_hist[0], sda_sync[1]};
         scl_filt <= maj3(scl_sync[1], scl_hist[0], scl_hist[1]);
         sda_filt <= maj3(sda_sync[1], sda_hist[0], sda_hist[1]);
      end
   end

   assign scl_c = scl_filt;
   assign sda_c = sda_filt;
`else
   assign scl_c = scl_sync[1];
   assign sda_c = sda_sync[1];
`endif

   always_ff @(posedge b_clk or posedge rst_i) begin
      if (rst_i) begin
         scl_q <= 1'b1;
         sda_q <= 1'b1;
      end else begin
         scl_q <= scl_c;
         sda_q <= sda_c;
      end
   end

   assign sda_lvl   = sda_c;
   assign scl_rise  =  scl_c & ~scl_q;
   assign scl_fall  = ~scl_c &  scl_q;
   assign start_det =  scl_c &  scl_q &  sda_q & ~sda_c;
   assign stop_det  =  scl_c &  scl_q & ~sda_q &  sda_c;

endmodule

// File: rtl/i2c_target_reg_mod.sv
// I2C target with register pointer: write = [addr W][ptr][data...], read = [addr R][data...].
// Define I2C_TARGET_GLITCH_FILT_EN to add a majority filter on SCL/SDA.
module i2c_target_reg_mod
   import i2c_pkg::*;
#(
   parameter logic [6:0] par_slv_addr = 7'h39,
   parameter int         par_reg_aw   = 8
) (
   input  logic                  b_clk,
   input  logic                  rst_i,
   input  logic                  scl_i,
   input  logic                  sda_i,
   output logic                  sda_oe_o,
   output logic [par_reg_aw-1:0] reg_addr_o,
   output logic [7:0]            reg_wdata_o,
   output logic                  reg_wr_o,
   output logic                  reg_rd_o,
   input  logic [7:0]            reg_rdata_i,
   output logic                  busy_o
);

   localparam logic [par_reg_aw-1:0] ptr_one = 1;

   i2c_state_e state;
   logic [7:0] shift_q;
   logic [2:0] bit_cnt;
   logic       rw_q;
   logic       phase_q;
   logic       load_q;
   logic       sda_lvl;
   logic       scl_rise;
   logic       scl_fall;
   logic       start_det;
   logic       stop_det;
   logic [7:0] rx_byte;

   i2c_bus_cond_mod u_cond (
      .b_clk     (b_clk),
      .rst_i     (rst_i),
      .scl_i     (scl_i),
      .sda_i     (sda_i),
      .sda_lvl   (sda_lvl),
      .scl_rise  (scl_rise),
      .scl_fall  (scl_fall),
      .start_det (start_det),
      .stop_det  (stop_det)
   );

   assign rx_byte = {shift_q[6:0], sda_lvl};

   always_ff @(posedge b_clk or posedge rst_i) begin
      if (rst_i) begin
         state       <= IDLE;
         shift_q     <= '0;
         bit_cnt     <= '0;
         rw_q        <= 1'b0;
         phase_q     <= 1'b0;
         load_q      <= 1'b0;
         sda_oe_o    <= 1'b0;
         reg_addr_o  <= '0;
         reg_wdata_o <= '0;
         reg_wr_o    <= 1'b0;
         reg_rd_o    <= 1'b0;
         busy_o      <= 1'b0;
      end else begin
         reg_wr_o <= 1'b0;
         reg_rd_o <= 1'b0;
         load_q   <= reg_rd_o;
         if (stop_det) begin
            state    <= IDLE;
            sda_oe_o <= 1'b0;
            busy_o   <= 1'b0;
            load_q   <= 1'b0;
         end else if (start_det) begin
            state    <= ADDR;
            bit_cnt  <= '0;
            sda_oe_o <= 1'b0;
            load_q   <= 1'b0;
         end else begin
            case (state)
               ADDR, PTR, WDATA: begin
                  if (scl_rise) begin
                     shift_q <= rx_byte;
                     bit_cnt <= bit_cnt + 3'd1;
                     if (bit_cnt == 3'd7) begin
                        phase_q <= 1'b0;
                        if (state == ADDR) begin
                           if (rx_byte[7:1] == par_slv_addr) begin
                              state  <= ADDR_ACK;
                              rw_q   <= rx_byte[0];
                              busy_o <= 1'b1;
                           end else begin
                              state  <= WAIT_STOP;
                              busy_o <= 1'b0;
                           end
                        end else if (state == PTR) begin
                           state      <= PTR_ACK;
                           reg_addr_o <= rx_byte[par_reg_aw-1:0];
                        end else begin
                           state       <= WDATA_ACK;
                           reg_wdata_o <= rx_byte;
                           reg_wr_o    <= 1'b1;
                        end
                     end
                  end
               end
               // First falling edge starts the ACK, second ends it.
               ADDR_ACK, PTR_ACK, WDATA_ACK: begin
                  if (scl_fall) begin
                     if (!phase_q) begin
                        sda_oe_o <= 1'b1;
                        phase_q  <= 1'b1;
                     end else begin
                        phase_q <= 1'b0;
                        bit_cnt <= '0;
                        if (state == ADDR_ACK && rw_q) begin
                           state    <= RDATA;
                           reg_rd_o <= 1'b1;
                        end else begin
                           sda_oe_o <= 1'b0;
                           state    <= (state == ADDR_ACK) ? PTR : WDATA;
                           if (state == WDATA_ACK)
                              reg_addr_o <= reg_addr_o + ptr_one;
                        end
                     end
                  end
               end
               RDATA: begin
                  if (load_q) begin
                     shift_q  <= reg_rdata_i;
                     sda_oe_o <= ~reg_rdata_i[7];
                  end else if (scl_rise) begin
                     bit_cnt <= bit_cnt + 3'd1;
                     if (bit_cnt == 3'd7) begin
                        state   <= RDATA_ACK;
                        phase_q <= 1'b0;
                     end
                  end else if (scl_fall) begin
                     shift_q  <= {shift_q[6:0], 1'b0};
                     sda_oe_o <= ~shift_q[6];
                  end
               end
               RDATA_ACK: begin
                  if (scl_fall) begin
                     if (!phase_q) begin
                        sda_oe_o <= 1'b0;
                     end else begin
                        state    <= RDATA;
                        reg_rd_o <= 1'b1;
                        bit_cnt  <= '0;
                     end
                  end else if (scl_rise) begin
                     if (sda_lvl == NACK) begin
                        state <= WAIT_STOP;
                     end else begin
                        phase_q    <= 1'b1;
                        reg_addr_o <= reg_addr_o + ptr_one;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule
